// File: rtl/bram_pim_acc_if.sv
// Request/response bundle for the PIM accumulate BRAM: valid/ready request
// port, fixed-latency response port and the sticky overflow flag.
interface bram_pim_acc_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  ovf_sticky;

  modport master (
    output req_valid, req_op, req_addr, req_data,
    input  req_ready, rsp_valid, rsp_data, ovf_sticky
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_data,
    output req_ready, rsp_valid, rsp_data, ovf_sticky
  );
endinterface

// File: rtl/bram_pim_acc.sv
// Banked single-port BRAM with in-memory READ / WRITE / ACC / RDCLR operations.
// ACC and RDCLR hold the port for a second (writeback) cycle, so no forwarding is needed.
module bram_pim_acc #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_MAXADDR = 11,
  parameter int SATURATE    = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  bram_pim_acc_if.slave  bus
);

  localparam int NUM_BANKS = 2 ** (ADDR_WIDTH - MEM_MAXADDR);
  localparam int BANK_W    = (ADDR_WIDTH > MEM_MAXADDR) ? (ADDR_WIDTH - MEM_MAXADDR) : 1;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ACC   = 2'b10;
  localparam logic [1:0] OP_RDCLR = 2'b11;

  typedef enum logic {ST_IDLE, ST_WB} state_e;

  // Returns {carry, result}; the carry is kept even when the result is clamped.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[DATA_WIDTH] && (SATURATE != 0)) s[DATA_WIDTH-1:0] = '1;
    return s;
  endfunction

  state_e                 state_q, state_d;
  logic                   rdy_q, rdy_d;
  logic                   rd_vld_p1_q, rd_vld_p1_d;
  logic                   acc_vld_p2_q, acc_vld_p2_d;
  logic                   ovf_q, ovf_d;

  logic [BANK_W-1:0]      bank_p1_q, bank_p1_d;
  logic [MEM_MAXADDR-1:0] addr_p1_q, addr_p1_d;
  logic [DATA_WIDTH-1:0]  addend_p1_q, addend_p1_d;
  logic                   is_acc_p1_q, is_acc_p1_d;
  logic [DATA_WIDTH-1:0]  res_p2_q, res_p2_d;

  logic                   accept;
  logic [BANK_W-1:0]      req_bank;
  logic [BANK_W-1:0]      port_bank;
  logic [MEM_MAXADDR-1:0] port_addr;
  logic                   port_we;
  logic [DATA_WIDTH-1:0]  port_din;
  logic [DATA_WIDTH-1:0]  mem_rd;
  logic [DATA_WIDTH:0]    sum;
  logic [DATA_WIDTH-1:0]  wb_data;
  logic [DATA_WIDTH-1:0]  bank_dout [2**BANK_W];

  generate
    if (ADDR_WIDTH > MEM_MAXADDR) begin : g_bank_sel
      assign req_bank = bus.req_addr[ADDR_WIDTH-1:MEM_MAXADDR];
    end else begin : g_single_bank
      assign req_bank = '0;
    end
  endgenerate

  // Read data always comes from the bank registered at acceptance.
  assign mem_rd  = bank_dout[bank_p1_q];
  assign sum     = sat_add(mem_rd, addend_p1_q);
  assign wb_data = is_acc_p1_q ? sum[DATA_WIDTH-1:0] : '0;

  assign bus.req_ready  = rdy_q & rst_n;
  assign accept         = bus.req_valid & bus.req_ready;
  assign bus.rsp_valid  = rd_vld_p1_q | acc_vld_p2_q;
  assign bus.rsp_data   = acc_vld_p2_q ? res_p2_q :
                          rd_vld_p1_q  ? mem_rd   : '0;
  assign bus.ovf_sticky = ovf_q;

  always_comb begin
    state_d      = state_q;
    rd_vld_p1_d  = 1'b0;
    acc_vld_p2_d = 1'b0;
    ovf_d        = ovf_q;
    bank_p1_d    = bank_p1_q;
    addr_p1_d    = addr_p1_q;
    addend_p1_d  = addend_p1_q;
    is_acc_p1_d  = is_acc_p1_q;
    res_p2_d     = res_p2_q;
    port_we      = 1'b0;
    port_bank    = req_bank;
    port_addr    = bus.req_addr[MEM_MAXADDR-1:0];
    port_din     = bus.req_data;

    if (state_q == ST_WB) begin
      // Writeback owns the port; reset in this cycle suppresses the write.
      port_we      = rst_n;
      port_bank    = bank_p1_q;
      port_addr    = addr_p1_q;
      port_din     = wb_data;
      acc_vld_p2_d = is_acc_p1_q;
      res_p2_d     = wb_data;
      ovf_d        = ovf_q | (is_acc_p1_q & sum[DATA_WIDTH]);
      state_d      = ST_IDLE;
    end else if (accept) begin
      port_we     = (bus.req_op == OP_WRITE);
      bank_p1_d   = req_bank;
      addr_p1_d   = bus.req_addr[MEM_MAXADDR-1:0];
      addend_p1_d = bus.req_data;
      is_acc_p1_d = (bus.req_op == OP_ACC);
      rd_vld_p1_d = (bus.req_op == OP_READ) || (bus.req_op == OP_RDCLR);
      if ((bus.req_op == OP_ACC) || (bus.req_op == OP_RDCLR)) state_d = ST_WB;
    end

    rdy_d = (state_d == ST_IDLE);
  end

  // Control state: reset applies here only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rdy_q        <= 1'b0;
      rd_vld_p1_q  <= 1'b0;
      acc_vld_p2_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_q        <= rdy_d;
      rd_vld_p1_q  <= rd_vld_p1_d;
      acc_vld_p2_q <= acc_vld_p2_d;
      ovf_q        <= ovf_d;
    end
  end

  // Data path: p1 captures the accepted request, p2 the writeback result.
  always_ff @(posedge clk) begin
    bank_p1_q   <= bank_p1_d;
    addr_p1_q   <= addr_p1_d;
    addend_p1_q <= addend_p1_d;
    is_acc_p1_q <= is_acc_p1_d;
    res_p2_q    <= res_p2_d;
  end

  generate
    for (genvar b = 0; b < 2**BANK_W; b++) begin : g_bank
      if (b < NUM_BANKS) begin : g_used
        logic                  bank_we;
        logic [DATA_WIDTH-1:0] dout;
        assign bank_we      = port_we & (port_bank == BANK_W'(b));
        assign bank_dout[b] = dout;
        for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
          singlePortRam #(.ADDR_WIDTH(MEM_MAXADDR)) u_ram (
            .clk  (clk),
            .we   (bank_we),
            .addr (port_addr),
            .din  (port_din[i]),
            .dout (dout[i])
          );
        end
      end else begin : g_unused
        assign bank_dout[b] = '0;
      end
    end
  endgenerate

endmodule

// Behavioural stand-in for the single-bit read-first BRAM primitive.
module singlePortRam #(
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  din,
  output logic                  dout
);
  logic mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
endmodule

// File: tb/tb_bram_pim_acc.sv
// Scoreboard bench: a saturating and a wrapping instance see identical requests;
// monitors pop expected {data, cycle} entries whenever rsp_valid is seen.
module tb_bram_pim_acc;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ACC   = 2'b10;
  localparam logic [1:0] OP_RDCLR = 2'b11;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q_s[$];
  exp_t q_w[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_pim_acc_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus_s ();
  bram_pim_acc_if #(.ADDR_WIDTH(12), .DATA_WIDTH(16)) bus_w ();

  assign bus_w.req_valid = bus_s.req_valid;
  assign bus_w.req_op    = bus_s.req_op;
  assign bus_w.req_addr  = bus_s.req_addr;
  assign bus_w.req_data  = bus_s.req_data;

  bram_pim_acc #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .MEM_MAXADDR(11), .SATURATE(1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  bram_pim_acc #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .MEM_MAXADDR(11), .SATURATE(0)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_w.slave)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitors: data and arrival cycle are both checked.
  always @(negedge clk) begin
    if (bus_s.rsp_valid === 1'b1) begin
      n_vec++;
      if (q_s.size() == 0) begin
        n_err++;
        $display("FAIL rsp_sat: unexpected response %h at cycle %0d", bus_s.rsp_data, cyc);
      end else begin
        exp_t e;
        e = q_s.pop_front();
        if (bus_s.rsp_data !== e.data || cyc != e.due) begin
          n_err++;
          $display("FAIL rsp_sat: got %h at cycle %0d expected %h at cycle %0d",
                   bus_s.rsp_data, cyc, e.data, e.due);
        end
      end
    end
    if (bus_w.rsp_valid === 1'b1) begin
      n_vec++;
      if (q_w.size() == 0) begin
        n_err++;
        $display("FAIL rsp_wrap: unexpected response %h at cycle %0d", bus_w.rsp_data, cyc);
      end else begin
        exp_t e;
        e = q_w.pop_front();
        if (bus_w.rsp_data !== e.data || cyc != e.due) begin
          n_err++;
          $display("FAIL rsp_wrap: got %h at cycle %0d expected %h at cycle %0d",
                   bus_w.rsp_data, cyc, e.data, e.due);
        end
      end
    end
  end

  // Presents a request, waits for acceptance and queues the expected responses.
  // Leaves req_valid high; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [15:0] data,
                       input logic [15:0] exp_s, input logic [15:0] exp_w, input bit want_rsp);
    bit ok;
    exp_t e;
    bus_s.req_valid = 1'b1;
    bus_s.req_op    = op;
    bus_s.req_addr  = addr;
    bus_s.req_data  = data;
    ok = 1'b0;
    for (int w = 0; w < 20; w++) begin
      @(negedge clk);
      if (bus_s.req_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: op %0d addr %h never accepted", op, addr);
    end else if (want_rsp && op != OP_WRITE) begin
      e.due  = cyc + ((op == OP_ACC) ? 2 : 1);
      e.data = exp_s;
      q_s.push_back(e);
      e.data = exp_w;
      q_w.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus_s.req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    bus_s.req_valid = 1'b0;
    bus_s.req_op    = OP_READ;
    bus_s.req_addr  = '0;
    bus_s.req_data  = '0;
    repeat (3) @(posedge clk);

    @(negedge clk);
    chk("reset_ready_sat", {15'd0, bus_s.req_ready}, 16'd0);
    chk("reset_ready_wrap", {15'd0, bus_w.req_ready}, 16'd0);
    chk("reset_rsp_valid", {14'd0, bus_s.rsp_valid, bus_w.rsp_valid}, 16'd0);
    chk("reset_rsp_data_sat", bus_s.rsp_data, 16'd0);
    chk("reset_rsp_data_wrap", bus_w.rsp_data, 16'd0);
    chk("reset_ovf", {14'd0, bus_s.ovf_sticky, bus_w.ovf_sticky}, 16'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_reset", {14'd0, bus_s.req_ready, bus_w.req_ready}, 16'h0003);

    // Write/read across the bank boundary, back-to-back.
    issue(OP_WRITE, 12'h7FF, 16'h1234, 16'h0, 16'h0, 1'b1);
    issue(OP_WRITE, 12'h800, 16'hABCD, 16'h0, 16'h0, 1'b1);
    issue(OP_READ,  12'h7FF, 16'h0000, 16'h1234, 16'h1234, 1'b1);
    issue(OP_READ,  12'h800, 16'h0000, 16'hABCD, 16'hABCD, 1'b1);
    idle(2);

    // Accumulate chain with req_valid held high.
    issue(OP_WRITE, 12'h010, 16'd5, 16'h0, 16'h0, 1'b1);
    issue(OP_ACC,   12'h010, 16'd7, 16'd12, 16'd12, 1'b1);
    @(negedge clk);
    chk("wb_ready_low_1", {15'd0, bus_s.req_ready}, 16'd0);
    issue(OP_ACC,   12'h010, 16'd3, 16'd15, 16'd15, 1'b1);
    @(negedge clk);
    chk("wb_ready_low_2", {15'd0, bus_s.req_ready}, 16'd0);
    issue(OP_READ,  12'h010, 16'd0, 16'd15, 16'd15, 1'b1);
    idle(3);

    // Exact fit: no overflow.
    issue(OP_WRITE, 12'h020, 16'hFFF0, 16'h0, 16'h0, 1'b1);
    issue(OP_ACC,   12'h020, 16'h000F, 16'hFFFF, 16'hFFFF, 1'b1);
    idle(3);
    chk("no_ovf_exact_fit", {14'd0, bus_s.ovf_sticky, bus_w.ovf_sticky}, 16'd0);

    // Overflow: clamp in one instance, wrap in the other.
    issue(OP_WRITE, 12'h020, 16'hFFF0, 16'h0, 16'h0, 1'b1);
    issue(OP_ACC,   12'h020, 16'h0020, 16'hFFFF, 16'h0010, 1'b1);
    issue(OP_READ,  12'h020, 16'h0000, 16'hFFFF, 16'h0010, 1'b1);
    idle(2);
    chk("ovf_set", {14'd0, bus_s.ovf_sticky, bus_w.ovf_sticky}, 16'h0003);

    // Read-clear.
    issue(OP_WRITE, 12'h030, 16'h55AA, 16'h0, 16'h0, 1'b1);
    issue(OP_RDCLR, 12'h030, 16'h0000, 16'h55AA, 16'h55AA, 1'b1);
    issue(OP_READ,  12'h030, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    idle(3);

    // Reset during writeback aborts the ACC.
    issue(OP_WRITE, 12'h040, 16'd9, 16'h0, 16'h0, 1'b1);
    issue(OP_ACC,   12'h040, 16'd1, 16'h0, 16'h0, 1'b0);
    rst_n           = 1'b0;
    bus_s.req_valid = 1'b0;
    @(negedge clk);
    chk("wb_rst_no_rsp", {14'd0, bus_s.rsp_valid, bus_w.rsp_valid}, 16'd0);
    @(posedge clk);
    #1;
    chk("wb_rst_ready", {14'd0, bus_s.req_ready, bus_w.req_ready}, 16'd0);
    chk("wb_rst_rsp_valid", {14'd0, bus_s.rsp_valid, bus_w.rsp_valid}, 16'd0);
    chk("wb_rst_rsp_data_sat", bus_s.rsp_data, 16'd0);
    chk("wb_rst_rsp_data_wrap", bus_w.rsp_data, 16'd0);
    chk("wb_rst_ovf_cleared", {14'd0, bus_s.ovf_sticky, bus_w.ovf_sticky}, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_wb_rst", {14'd0, bus_s.req_ready, bus_w.req_ready}, 16'h0003);
    issue(OP_READ, 12'h040, 16'h0, 16'd9, 16'd9, 1'b1);
    issue(OP_READ, 12'h030, 16'h0, 16'h0000, 16'h0000, 1'b1);
    issue(OP_READ, 12'h800, 16'h0, 16'hABCD, 16'hABCD, 1'b1);
    idle(4);

    chk("pending_sat", q_s.size()[15:0], 16'd0);
    chk("pending_wrap", q_w.size()[15:0], 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
